fetch_queue: RTL and testbench

Instruction fetch front-end for the Simple_CADD core. It owns the fetch address and issues single-outstanding read requests to instruction memory over a req/ack handshake. Returned words go into a small FIFO, and each entry is presented to decode with its address over a valid/ready handshake. A taken-branch input (ALU branch result plus immediate target) flushes the queue and redirects fetch.

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch front-end's three channels: memory read, decode delivery, branch redirect.
// Handshakes: a memory read completes in the cycle mem_req && mem_ack; a decode transfer occurs in the cycle inst_valid && inst_ready.
interface fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  branch_taken, branch_target, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output branch_taken, branch_target, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: single-outstanding memory reads feed a small FIFO of
// {pc, word} entries delivered to decode; a taken branch flushes and redirects fetch.
module fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.master    bus,
  output logic [1:0]       dbg_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic             ack;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] count_after_push;

  always_comb begin
    ack              = mem_req_q && bus.mem_ack;
    pop              = (count_q != '0) && bus.inst_ready;
    count_after_push = count_q - CNT_W'(pop) + CNT_W'(1);
    push             = 1'b0;
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    mem_req_d        = mem_req_q;
    mem_addr_d       = mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (count_q < FULL) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (ack) begin
          push       = 1'b1;
          fetch_pc_d = mem_addr_q + ADDR_W'(1);
          if (count_after_push < FULL) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end else begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (ack) begin
          state_d    = S_REQ;
          mem_addr_d = fetch_pc_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A redirect overrides any push; an unacked request must still be drained.
    if (bus.branch_taken) begin
      push       = 1'b0;
      fetch_pc_d = bus.branch_target;
      if (state_q == S_DRAIN || (state_q == S_REQ && !ack)) begin
        state_d    = S_DRAIN;
        mem_req_d  = 1'b1;
        mem_addr_d = mem_addr_q;
      end else begin
        state_d    = S_REQ;
        mem_req_d  = 1'b1;
        mem_addr_d = bus.branch_target;
      end
    end

    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    if (bus.branch_taken) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        data_q[wr_ptr_q] <= bus.mem_rdata;
        pc_q[wr_ptr_q]   <= mem_addr_q;
      end
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_data  = data_q[rd_ptr_q];
  assign bus.inst_pc    = pc_q[rd_ptr_q];
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized memory latency, decode stalls
// and redirects, checked against an address-stream reference model through an expected queue.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  fetch_queue_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  fetch_queue #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word at address a is 0x0100 + a.
  assign bus.mem_rdata = 16'h0100 + {8'h00, bus.mem_addr};

  int checks   = 0;
  int failures = 0;
  int ack_pct  = 100;
  int rdy_pct  = 100;
  int br_pct   = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  exp_fetch = 8'h00;
  logic        stale     = 1'b0;
  logic        pend      = 1'b0;
  logic [7:0]  pend_addr = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch address stream restarts at each redirect target and
  // advances by one per accepted word; words requested before a redirect are dropped.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      exp_q.delete();
      stale     = 1'b0;
      exp_fetch = 8'h00;
      pend      = 1'b0;
    end else begin
      if (pend) begin
        chk("req_held", 32'(bus.mem_req), 32'(1));
        chk("addr_held", 32'(bus.mem_addr), 32'(pend_addr));
      end
      if (bus.branch_taken) begin
        exp_q.delete();
        stale     = stale || (bus.mem_req && !bus.mem_ack);
        exp_fetch = bus.branch_target;
      end else if (bus.mem_req && bus.mem_ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(exp_fetch));
          exp_q.push_back({exp_fetch, 16'h0100 + {8'h00, exp_fetch}});
          chk("no_overflow", 32'(exp_q.size() <= DEPTH), 32'(1));
          exp_fetch = exp_fetch + 8'd1;
        end
      end
      pend      = bus.mem_req && !bus.mem_ack;
      pend_addr = bus.mem_addr;
    end
  end

  // Monitor: compares the queue head against the model whenever decode takes an entry.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst) begin
      chk("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
      if (bus.inst_valid && bus.inst_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", 32'(bus.inst_pc), 32'(e[23:16]));
        chk("inst_data", 32'(bus.inst_data), 32'(e[15:0]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.mem_ack       = ($urandom_range(0, 99) < ack_pct);
      bus.inst_ready    = ($urandom_range(0, 99) < rdy_pct);
      bus.branch_taken  = ($urandom_range(0, 99) < br_pct);
      bus.branch_target = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic wait_for_valid(input string name);
    int n = 0;
    while (!bus.inst_valid && n < 8) begin
      cyc(1);
      n++;
    end
    chk(name, 32'(bus.inst_valid), 32'(1));
  endtask

  initial begin
    int         n;
    logic [7:0] p;
    rst               = 1'b0;
    bus.mem_ack       = 1'b0;
    bus.inst_ready    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'(0));
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'(0));
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'(0));
    chk("rst_inst_data", 32'(bus.inst_data), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(0));

    // Streaming with zero-wait memory and an always-ready decoder.
    bus.mem_ack    = 1'b1;
    bus.inst_ready = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_first_req", 32'(bus.mem_req), 32'(1));
    chk("t1_first_addr", 32'(bus.mem_addr), 32'(0));
    wait_for_valid("t1_valid");
    chk("t1_first_pc", 32'(bus.inst_pc), 32'(0));
    n = 0;
    repeat (12) begin
      if (bus.inst_valid) n++;
      cyc(1);
    end
    chk("t1_throughput", 32'(n), 32'(12));

    // Decoder stalled: queue fills to DEPTH and fetch stops; one pop restarts it.
    rdy_pct        = 0;
    bus.inst_ready = 1'b0;
    do_reset();
    cyc(8);
    chk("t2_idle_req", 32'(bus.mem_req), 32'(0));
    chk("t2_head_pc", 32'(bus.inst_pc), 32'(0));
    chk("t2_state", 32'(dbg_state), 32'(0));
    bus.inst_ready = 1'b1;
    cyc(1);
    chk("t2_pop_pc", 32'(bus.inst_pc), 32'(1));
    cyc(1);
    chk("t2_restart_req", 32'(bus.mem_req), 32'(1));
    chk("t2_restart_addr", 32'(bus.mem_addr), 32'(4));

    // Redirect from IDLE with a full queue.
    cyc(2);
    chk("t3_pre_idle", 32'(bus.mem_req), 32'(0));
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h20;
    cyc(1);
    chk("t3_flush_valid", 32'(bus.inst_valid), 32'(0));
    chk("t3_redirect_req", 32'(bus.mem_req), 32'(1));
    chk("t3_redirect_addr", 32'(bus.mem_addr), 32'(8'h20));
    rdy_pct = 100;
    wait_for_valid("t3_valid");
    chk("t3_target_pc", 32'(bus.inst_pc), 32'(8'h20));

    // Redirect while a slow request to address 5 is in flight.
    do_reset();
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 8'd5) && n < 20) begin
      cyc(1);
      n++;
    end
    chk("t4_found_addr5", 32'(bus.mem_addr), 32'(5));
    ack_pct     = 0;
    bus.mem_ack = 1'b0;
    cyc(1);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h20;
    cyc(1);
    chk("t4_drain_state", 32'(dbg_state), 32'(2));
    chk("t4_drain_addr", 32'(bus.mem_addr), 32'(5));
    chk("t4_drain_req", 32'(bus.mem_req), 32'(1));
    cyc(1);
    ack_pct     = 100;
    bus.mem_ack = 1'b1;
    cyc(1);
    chk("t4_after_drain_addr", 32'(bus.mem_addr), 32'(8'h20));
    chk("t4_after_drain_state", 32'(dbg_state), 32'(1));
    wait_for_valid("t4_valid");
    chk("t4_target_pc", 32'(bus.inst_pc), 32'(8'h20));

    // Address wrap after a redirect near the top of the space.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'hFE;
    cyc(1);
    wait_for_valid("t5_valid");
    p = 8'hFE;
    repeat (4) begin
      chk("t5_wrap_pc", 32'(bus.inst_pc), 32'(p));
      p = p + 8'd1;
      cyc(1);
    end

    // Asynchronous reset in the middle of a request.
    ack_pct = 60;
    rdy_pct = 60;
    cyc(20);
    n = 0;
    while (!bus.mem_req && n < 10) begin
      cyc(1);
      n++;
    end
    chk("t6_pre_req", 32'(bus.mem_req), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("t6_async_req", 32'(bus.mem_req), 32'(0));
    chk("t6_async_valid", 32'(bus.inst_valid), 32'(0));
    chk("t6_async_state", 32'(dbg_state), 32'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_restart_req", 32'(bus.mem_req), 32'(1));
    chk("t6_restart_addr", 32'(bus.mem_addr), 32'(0));

    // Randomized traffic with redirects.
    ack_pct = 70;
    rdy_pct = 60;
    br_pct  = 4;
    cyc(3000);
    ack_pct = 100;
    rdy_pct = 100;
    br_pct  = 10;
    cyc(1000);
    ack_pct = 40;
    rdy_pct = 30;
    br_pct  = 8;
    cyc(1000);
    br_pct = 0;
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
